// File: rtl/id_ex_stage_if.sv
// Decoded-instruction bus from the ID stage into the ID/EX register.
// The ID stage drives through the master modport and id_ex_stage consumes through the slave modport.
interface id_ex_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          valid;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic [DW-1:0] imm;
  logic [4:0]    shamt;
  logic [RW-1:0] rs;
  logic [RW-1:0] rt;
  logic [RW-1:0] rd;
  logic [3:0]    alu_control;
  logic          alu_src;
  logic          shift_sel;
  logic          reg_dst;
  logic          reg_write;
  logic          mem_read;
  logic          mem_write;
  logic          mem_to_reg;
  logic          branch;
  logic [DW-1:0] pc4;

  modport master (
    output valid, rs_val, rt_val, imm, shamt, rs, rt, rd, alu_control,
           alu_src, shift_sel, reg_dst, reg_write, mem_read, mem_write,
           mem_to_reg, branch, pc4
  );

  modport slave (
    input  valid, rs_val, rt_val, imm, shamt, rs, rt, rd, alu_control,
           alu_src, shift_sel, reg_dst, reg_write, mem_read, mem_write,
           mem_to_reg, branch, pc4
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side forwarding, ALU operand selection and load-use hazard detection.
// Each register update chooses, in priority order, between flush, stall, load-use bubble and capture.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  id,
  input  logic          stall_in,
  input  logic          flush,
  input  logic          exm_RegWrite,
  input  logic [RW-1:0] exm_WriteReg,
  input  logic [DW-1:0] exm_result,
  input  logic          mwb_RegWrite,
  input  logic [RW-1:0] mwb_WriteReg,
  input  logic [DW-1:0] mwb_result,
  output logic [DW-1:0] Ain,
  output logic [DW-1:0] Bin,
  output logic [3:0]    ALUControl,
  output logic [DW-1:0] StoreData,
  output logic [RW-1:0] WriteReg,
  output logic          RegWrite,
  output logic          MemRead,
  output logic          MemWrite,
  output logic          MemtoReg,
  output logic          Branch,
  output logic [DW-1:0] pc4_ex,
  output logic          ex_valid,
  output logic          load_use_stall
);

  logic          valid_r;
  logic [DW-1:0] rs_val_r;
  logic [DW-1:0] rt_val_r;
  logic [DW-1:0] imm_r;
  logic [4:0]    shamt_r;
  logic [RW-1:0] rs_r;
  logic [RW-1:0] rt_r;
  logic [RW-1:0] rd_r;
  logic [3:0]    alu_ctrl_r;
  logic          alu_src_r;
  logic          shift_sel_r;
  logic          reg_dst_r;
  logic          reg_write_r;
  logic          mem_read_r;
  logic          mem_write_r;
  logic          mem_to_reg_r;
  logic          branch_r;
  logic [DW-1:0] pc4_r;

  logic [DW-1:0] fwd_a_s;
  logic [DW-1:0] fwd_b_s;
  logic          hazard_s;

  // Hazard is judged against the registered rt, so a bubble (valid=0, MemRead=0) can never raise it.
  assign hazard_s = valid_r & mem_read_r & (rt_r != {RW{1'b0}}) & id.valid &
                    ((rt_r == id.rs) | (rt_r == id.rt));

  // Pipeline register: flush beats stall, stall beats the load-use bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush || (!stall_in && hazard_s)) begin
      if (!rst_n || flush || hazard_s) begin
        valid_r      <= 1'b0;
        rs_val_r     <= {DW{1'b0}};
        rt_val_r     <= {DW{1'b0}};
        imm_r        <= {DW{1'b0}};
        shamt_r      <= 5'd0;
        rs_r         <= {RW{1'b0}};
        rt_r         <= {RW{1'b0}};
        rd_r         <= {RW{1'b0}};
        alu_ctrl_r   <= 4'b0000;
        alu_src_r    <= 1'b0;
        shift_sel_r  <= 1'b0;
        reg_dst_r    <= 1'b0;
        reg_write_r  <= 1'b0;
        mem_read_r   <= 1'b0;
        mem_write_r  <= 1'b0;
        mem_to_reg_r <= 1'b0;
        branch_r     <= 1'b0;
        pc4_r        <= {DW{1'b0}};
      end
    end else if (!stall_in) begin
      valid_r      <= id.valid;
      rs_val_r     <= id.rs_val;
      rt_val_r     <= id.rt_val;
      imm_r        <= id.imm;
      shamt_r      <= id.shamt;
      rs_r         <= id.rs;
      rt_r         <= id.rt;
      rd_r         <= id.rd;
      alu_ctrl_r   <= id.alu_control;
      alu_src_r    <= id.alu_src;
      shift_sel_r  <= id.shift_sel;
      reg_dst_r    <= id.reg_dst;
      reg_write_r  <= id.reg_write;
      mem_read_r   <= id.mem_read;
      mem_write_r  <= id.mem_write;
      mem_to_reg_r <= id.mem_to_reg;
      branch_r     <= id.branch;
      pc4_r        <= id.pc4;
    end
  end

  // Operand forwarding: EX/MEM is younger than MEM/WB so it wins; $0 is never forwarded.
  always_comb begin
    fwd_a_s = rs_val_r;
    fwd_b_s = rt_val_r;
    if (exm_RegWrite && (exm_WriteReg != {RW{1'b0}}) && (exm_WriteReg == rs_r)) begin
      fwd_a_s = exm_result;
    end else if (mwb_RegWrite && (mwb_WriteReg != {RW{1'b0}}) && (mwb_WriteReg == rs_r)) begin
      fwd_a_s = mwb_result;
    end else begin
      fwd_a_s = rs_val_r;
    end
    if (exm_RegWrite && (exm_WriteReg != {RW{1'b0}}) && (exm_WriteReg == rt_r)) begin
      fwd_b_s = exm_result;
    end else if (mwb_RegWrite && (mwb_WriteReg != {RW{1'b0}}) && (mwb_WriteReg == rt_r)) begin
      fwd_b_s = mwb_result;
    end else begin
      fwd_b_s = rt_val_r;
    end
  end

  // Branches ignore ALUSrc so beq/bne always compare rs against rt.
  assign Ain            = shift_sel_r ? {{(DW-5){1'b0}}, shamt_r} : fwd_a_s;
  assign Bin            = (alu_src_r && !branch_r) ? imm_r : fwd_b_s;
  assign StoreData      = fwd_b_s;
  assign WriteReg       = reg_dst_r ? rd_r : rt_r;
  assign ALUControl     = alu_ctrl_r;
  assign RegWrite       = reg_write_r;
  assign MemRead        = mem_read_r;
  assign MemWrite       = mem_write_r;
  assign MemtoReg       = mem_to_reg_r;
  assign Branch         = branch_r;
  assign pc4_ex         = pc4_r;
  assign ex_valid       = valid_r;
  assign load_use_stall = hazard_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: forwarding, $0 guard, load-use, shift/immediate, stall/flush, reset.
// Expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk;
  logic          rst_n;
  logic          stall_in;
  logic          flush;
  logic          exm_RegWrite;
  logic [RW-1:0] exm_WriteReg;
  logic [DW-1:0] exm_result;
  logic          mwb_RegWrite;
  logic [RW-1:0] mwb_WriteReg;
  logic [DW-1:0] mwb_result;
  logic [DW-1:0] Ain;
  logic [DW-1:0] Bin;
  logic [3:0]    ALUControl;
  logic [DW-1:0] StoreData;
  logic [RW-1:0] WriteReg;
  logic          RegWrite;
  logic          MemRead;
  logic          MemWrite;
  logic          MemtoReg;
  logic          Branch;
  logic [DW-1:0] pc4_ex;
  logic          ex_valid;
  logic          load_use_stall;

  int total;
  int bad;

  id_ex_stage_if #(.DW(DW), .RW(RW)) idb ();

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id             (idb),
    .stall_in       (stall_in),
    .flush          (flush),
    .exm_RegWrite   (exm_RegWrite),
    .exm_WriteReg   (exm_WriteReg),
    .exm_result     (exm_result),
    .mwb_RegWrite   (mwb_RegWrite),
    .mwb_WriteReg   (mwb_WriteReg),
    .mwb_result     (mwb_result),
    .Ain            (Ain),
    .Bin            (Bin),
    .ALUControl     (ALUControl),
    .StoreData      (StoreData),
    .WriteReg       (WriteReg),
    .RegWrite       (RegWrite),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .MemtoReg       (MemtoReg),
    .Branch         (Branch),
    .pc4_ex         (pc4_ex),
    .ex_valid       (ex_valid),
    .load_use_stall (load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    idb.valid = 1'b0;       idb.rs_val = 32'd0;     idb.rt_val = 32'd0;
    idb.imm = 32'd0;        idb.shamt = 5'd0;       idb.rs = 5'd0;
    idb.rt = 5'd0;          idb.rd = 5'd0;          idb.alu_control = 4'b0000;
    idb.alu_src = 1'b0;     idb.shift_sel = 1'b0;   idb.reg_dst = 1'b0;
    idb.reg_write = 1'b0;   idb.mem_read = 1'b0;    idb.mem_write = 1'b0;
    idb.mem_to_reg = 1'b0;  idb.branch = 1'b0;      idb.pc4 = 32'd0;
  endtask

  task automatic clear_fwd();
    exm_RegWrite = 1'b0; exm_WriteReg = 5'd0; exm_result = 32'd0;
    mwb_RegWrite = 1'b0; mwb_WriteReg = 5'd0; mwb_result = 32'd0;
  endtask

  task automatic set_lw_r4();
    clear_id();
    idb.valid = 1'b1; idb.rs = 5'd1; idb.rs_val = 32'h100; idb.rt = 5'd4;
    idb.alu_src = 1'b1; idb.imm = 32'd8; idb.mem_read = 1'b1; idb.mem_to_reg = 1'b1;
    idb.reg_write = 1'b1; idb.alu_control = 4'b0010;
  endtask

  task automatic set_add_r4();
    clear_id();
    idb.valid = 1'b1; idb.rs = 5'd4; idb.rs_val = 32'h0; idb.rt = 5'd5; idb.rt_val = 32'd3;
    idb.rd = 5'd6; idb.reg_dst = 1'b1; idb.reg_write = 1'b1; idb.alu_control = 4'b0010;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0; stall_in = 1'b0; flush = 1'b0;
    clear_id();
    clear_fwd();
    #1;
    chk("rst_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_ain", {32'd0, Ain}, 64'd0);
    chk("rst_bin", {32'd0, Bin}, 64'd0);
    chk("rst_store", {32'd0, StoreData}, 64'd0);
    chk("rst_wreg", {59'd0, WriteReg}, 64'd0);
    chk("rst_lus", {63'd0, load_use_stall}, 64'd0);
    #2 rst_n = 1'b1;

    // double forward: add $10 = $8 + $9
    clear_id();
    idb.valid = 1'b1; idb.rs = 5'd8; idb.rs_val = 32'h99; idb.rt = 5'd9; idb.rt_val = 32'd5;
    idb.rd = 5'd10; idb.reg_dst = 1'b1; idb.reg_write = 1'b1; idb.alu_control = 4'b0010;
    idb.pc4 = 32'h104;
    step();
    exm_RegWrite = 1'b1; exm_WriteReg = 5'd8; exm_result = 32'h10;
    mwb_RegWrite = 1'b1; mwb_WriteReg = 5'd8; mwb_result = 32'h20;
    #1;
    chk("dfwd_ain", {32'd0, Ain}, 64'h10);
    chk("dfwd_bin", {32'd0, Bin}, 64'd5);
    chk("dfwd_alu", {60'd0, ALUControl}, 64'b0010);
    chk("dfwd_wreg", {59'd0, WriteReg}, 64'd10);
    chk("dfwd_valid", {63'd0, ex_valid}, 64'd1);
    chk("dfwd_pc4", {32'd0, pc4_ex}, 64'h104);
    exm_RegWrite = 1'b0;
    #1;
    chk("mwb_ain", {32'd0, Ain}, 64'h20);
    mwb_RegWrite = 1'b0;
    #1;
    chk("nofwd_ain", {32'd0, Ain}, 64'h99);

    // $0 guard
    clear_id();
    idb.valid = 1'b1; idb.alu_control = 4'b0010;
    exm_RegWrite = 1'b1; exm_WriteReg = 5'd0; exm_result = 32'hDEAD;
    mwb_RegWrite = 1'b1; mwb_WriteReg = 5'd0; mwb_result = 32'hBEEF;
    step();
    chk("r0_ain", {32'd0, Ain}, 64'd0);
    chk("r0_bin", {32'd0, Bin}, 64'd0);
    clear_fwd();

    // load-use
    set_lw_r4();
    step();
    chk("lw_bin", {32'd0, Bin}, 64'd8);
    chk("lw_wreg", {59'd0, WriteReg}, 64'd4);
    chk("lw_memread", {63'd0, MemRead}, 64'd1);
    set_add_r4();
    idb.valid = 1'b0;
    #1;
    chk("lus_idinvalid", {63'd0, load_use_stall}, 64'd0);
    idb.valid = 1'b1;
    #1;
    chk("lus_set", {63'd0, load_use_stall}, 64'd1);
    step();
    chk("lus_bub_valid", {63'd0, ex_valid}, 64'd0);
    chk("lus_bub_regwr", {63'd0, RegWrite}, 64'd0);
    chk("lus_clear", {63'd0, load_use_stall}, 64'd0);
    mwb_RegWrite = 1'b1; mwb_WriteReg = 5'd4; mwb_result = 32'h77;
    step();
    chk("lus_re_ain", {32'd0, Ain}, 64'h77);
    chk("lus_re_bin", {32'd0, Bin}, 64'd3);
    chk("lus_re_valid", {63'd0, ex_valid}, 64'd1);
    clear_fwd();

    // shift and immediates
    clear_id();
    idb.valid = 1'b1; idb.shift_sel = 1'b1; idb.shamt = 5'd3; idb.rt = 5'd2; idb.rt_val = 32'd1;
    idb.rs = 5'd1; idb.rs_val = 32'h55; idb.alu_control = 4'b0100;
    step();
    chk("sll_ain", {32'd0, Ain}, 64'd3);
    chk("sll_bin", {32'd0, Bin}, 64'd1);
    clear_id();
    idb.valid = 1'b1; idb.rs = 5'd1; idb.rs_val = 32'd7; idb.rt = 5'd6; idb.rt_val = 32'h55;
    idb.imm = 32'hFFFF_FFFC; idb.alu_src = 1'b1; idb.reg_write = 1'b1; idb.alu_control = 4'b0010;
    step();
    chk("addi_bin", {32'd0, Bin}, 64'hFFFF_FFFC);
    chk("addi_store", {32'd0, StoreData}, 64'h55);
    chk("addi_wreg", {59'd0, WriteReg}, 64'd6);
    clear_id();
    idb.valid = 1'b1; idb.rs = 5'd1; idb.rt = 5'd7; idb.rt_val = 32'h11; idb.imm = 32'd4;
    idb.alu_src = 1'b1; idb.mem_write = 1'b1; idb.alu_control = 4'b0010;
    exm_RegWrite = 1'b1; exm_WriteReg = 5'd7; exm_result = 32'hABC;
    step();
    chk("sw_store", {32'd0, StoreData}, 64'hABC);
    chk("sw_bin", {32'd0, Bin}, 64'd4);
    chk("sw_memwrite", {63'd0, MemWrite}, 64'd1);
    clear_fwd();
    clear_id();
    idb.valid = 1'b1; idb.branch = 1'b1; idb.alu_src = 1'b1; idb.imm = 32'h40;
    idb.rt = 5'd3; idb.rt_val = 32'h33; idb.alu_control = 4'b1001;
    step();
    chk("beq_bin", {32'd0, Bin}, 64'h33);
    chk("beq_branch", {63'd0, Branch}, 64'd1);

    // stall hold for 3 cycles
    clear_id();
    idb.valid = 1'b1; idb.rs = 5'd2; idb.rs_val = 32'h1234; idb.alu_control = 4'b0110;
    idb.pc4 = 32'h400; idb.reg_write = 1'b1;
    step();
    clear_id();
    idb.valid = 1'b1; idb.rs = 5'd3; idb.rs_val = 32'h9999; idb.alu_control = 4'b0001;
    idb.pc4 = 32'h800;
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_alu", {60'd0, ALUControl}, 64'b0110);
      chk("stall_ain", {32'd0, Ain}, 64'h1234);
      chk("stall_pc4", {32'd0, pc4_ex}, 64'h400);
    end
    flush = 1'b1;
    step();
    chk("flush_valid", {63'd0, ex_valid}, 64'd0);
    chk("flush_alu", {60'd0, ALUControl}, 64'd0);
    chk("flush_pc4", {32'd0, pc4_ex}, 64'd0);
    flush = 1'b0;
    stall_in = 1'b0;

    // stall with pending hazard holds, then flush with hazard bubbles
    set_lw_r4();
    step();
    set_add_r4();
    stall_in = 1'b1;
    step();
    chk("stallhz_valid", {63'd0, ex_valid}, 64'd1);
    chk("stallhz_lus", {63'd0, load_use_stall}, 64'd1);
    stall_in = 1'b0;
    flush = 1'b1;
    step();
    chk("flushhz_valid", {63'd0, ex_valid}, 64'd0);
    flush = 1'b0;

    // asynchronous reset mid-stream
    clear_id();
    idb.valid = 1'b1; idb.reg_write = 1'b1; idb.alu_control = 4'b0111; idb.rs = 5'd2; idb.rs_val = 32'h5;
    step();
    chk("pre_rst_valid", {63'd0, ex_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, ex_valid}, 64'd0);
    chk("arst_alu", {60'd0, ALUControl}, 64'd0);
    chk("arst_regwr", {63'd0, RegWrite}, 64'd0);
    chk("arst_ain", {32'd0, Ain}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register plus EX-side operand formation for the 5-stage pipelined CPU. Captures decoded instruction fields and control from ID each cycle and resolves EX/MEM and MEM/WB forwarding. Produces the ALU operands (Ain, Bin, ALUControl) and the signals the EX/MEM register consumes. Also detects load-use hazards and handles stall and flush.

Parameters:
DW, 32, datapath width
RW, 5, register index width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs_val, id_rt_val  in  DW  register-file read data
id_imm  in  DW  sign/zero-extended immediate, extended in ID
id_shamt  in  5  shift amount field
id_rs, id_rt, id_rd  in  RW  register indices
id_ALUControl  in  4  ALU opcode (ALU encoding)
id_ALUSrc, id_ShiftSel, id_RegDst, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_Branch  in  1 each  decoded control
id_pc4  in  DW  PC+4 of the ID instruction
stall_in  in  1  global freeze (memory stall)
flush  in  1  taken branch: squash the ID instruction
exm_RegWrite  in  1  EX/MEM writes a register
exm_WriteReg  in  RW  EX/MEM destination register
exm_result  in  DW  EX/MEM ALU result
mwb_RegWrite  in  1  MEM/WB writes a register
mwb_WriteReg  in  RW  MEM/WB destination register
mwb_result  in  DW  MEM/WB write-back data
Ain, Bin  out  DW  ALU operands
ALUControl  out  4  registered ALU opcode
StoreData  out  DW  forwarded rt value for stores
WriteReg  out  RW  destination: rd if RegDst, else rt
RegWrite, MemRead, MemWrite, MemtoReg, Branch  out  1 each  registered control
pc4_ex  out  DW  registered PC+4
ex_valid  out  1  EX holds a real instruction
load_use_stall  out  1  combinational hazard request to PC/IF-ID

Behaviour:
- Reset (rst_n low, asynchronous): all registered state cleared to a bubble. Valid=0, all control=0, ALUControl=4'b0000, indices=0, data=0. Outputs are therefore Ain=Bin=StoreData=0, WriteReg=0 and load_use_stall=0. Reset asserted mid-stream discards the held instruction immediately.
- Register update at each rising clk, in priority order:
  1. flush → load bubble.
  2. stall_in → hold all state.
  3. load_use_stall → load bubble.
  4. Otherwise → capture all id_* inputs; ex_valid <= id_valid.
- load_use_stall = ex_valid & MemRead & (rt_ex != 0) & id_valid & (rt_ex == id_rs | rt_ex == id_rt). The comparison uses the registered rt, not WriteReg.
- Latency: one cycle from ID capture to valid Ain/Bin. Forwarding is combinational from the registered fields and the exm_*/mwb_* inputs.
- Forwarded rs (fA), from the registered rs index:
  - If exm_RegWrite & exm_WriteReg != 0 & exm_WriteReg == rs_ex → exm_result.
  - Else if mwb_RegWrite & mwb_WriteReg != 0 & mwb_WriteReg == rs_ex → mwb_result.
  - Else the registered rs value.
- Forwarded rt (fB): same rule using rt_ex. EX/MEM always beats MEM/WB. Register 0 is never forwarded.
- Ain = ShiftSel ? {27'b0, shamt} : fA. The ALU shifts Bin by Ain.
- Bin = (ALUSrc & !Branch) ? imm : fB. Branch forces fB so beq/bne (ALUControl 1001/1010) compare rs and rt.
- StoreData = fB regardless of ALUSrc.
- WriteReg = RegDst ? rd_ex : rt_ex.
- Bubble outputs: RegWrite=MemWrite=MemRead=Branch=0, so a bubble can never trigger a write, branch or hazard.
- Simultaneous flush and load_use_stall: flush wins; a bubble results either way. stall_in with a pending hazard: hold; load_use_stall stays asserted while the condition holds.

Test Plan:
- Reset: drive rst_n=0 mid-operation with valid instruction loaded → outputs clear the same cycle without a clk edge; ex_valid=0, ALUControl=0, RegWrite=0.
- Double forward: EX/MEM writes $8=0x10, MEM/WB writes $8=0x20; ID add rs=$8, rt=$9 (reg val 5) → Ain=0x10 (EX/MEM priority), Bin=5, ALUControl=0010.
- $0 guard: exm_WriteReg=0, exm_RegWrite=1, exm_result=0xDEAD; ID rs=$0 with rs_val=0 → Ain=0.
- Load-use: EX lw rt=$4; ID add rs=$4 → load_use_stall=1; next edge ex_valid=0, RegWrite=0. Following cycle the re-presented add loads and gets $4 from MEM/WB.
- Shift and immediate: sll with shamt=3, rt=0x1 → Ain=3, Bin=1. addi imm=0xFFFF_FFFC → Bin=0xFFFF_FFFC and StoreData=fB. sw with ALUSrc=1 → StoreData=forwarded rt.
- Stall/flush: stall_in=1 for 3 cycles → all outputs frozen. flush=1 together with stall_in=1 → bubble next edge.
